// File: rtl/alu_defs_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : alu_defs_pkg
//  Description : Shared definitions for the ALU command sequencer: ALUOp
//                encodings, command opcodes, FSM states and the command
//                decode helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_defs_pkg;

  // ALUOp encodings understood by the 6-bit ALU ({Ainvert, Bnegate, op[1:0]})
  localparam logic [3:0] ALUOP_AND = 4'b0000;
  localparam logic [3:0] ALUOP_OR  = 4'b0001;
  localparam logic [3:0] ALUOP_ADD = 4'b0010;
  localparam logic [3:0] ALUOP_SUB = 4'b0110;
  localparam logic [3:0] ALUOP_NOR = 4'b1100;

  // Command opcodes on cmd_op; anything above CMD_NOR is illegal
  localparam logic [2:0] CMD_AND = 3'd0;
  localparam logic [2:0] CMD_OR  = 3'd1;
  localparam logic [2:0] CMD_ADD = 3'd2;
  localparam logic [2:0] CMD_SUB = 3'd3;
  localparam logic [2:0] CMD_NOR = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // arith marks ops whose CarryOut is meaningful to the consumer
  typedef struct packed {
    logic [3:0] alu_op;
    logic       carry_in;
    logic       err;
    logic       arith;
  } dec_t;

  function automatic dec_t decode_cmd(input logic [2:0] op);
    dec_t d;
    d.alu_op   = ALUOP_AND;
    d.carry_in = 1'b0;
    d.err      = 1'b0;
    d.arith    = 1'b0;
    case (op)
      CMD_AND: d.alu_op = ALUOP_AND;
      CMD_OR:  d.alu_op = ALUOP_OR;
      CMD_ADD: begin
        d.alu_op = ALUOP_ADD;
        d.arith  = 1'b1;
      end
      CMD_SUB: begin
        d.alu_op   = ALUOP_SUB;
        d.carry_in = 1'b1;
        d.arith    = 1'b1;
      end
      CMD_NOR: d.alu_op = ALUOP_NOR;
      default: d.err = 1'b1;
    endcase
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock show-ahead FIFO. Pointers wrap modulo DEPTH;
//                a separate occupancy count produces full and empty.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 15,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // A push while full is dropped even if a pop happens in the same cycle
  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;
  assign o_data    = r_mem[r_rd_ptr];

  // Storage array; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_cmd_sequencer
//  Description : Issue stage for the 6-bit combinational ALU. Buffers
//                commands, drives the ALU from registers, captures the
//                result and returns it in order over valid/ready.
//                Optional macro ALU_SEQ_STATS_EN adds a saturating
//                completed-response counter on rsp_count.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_cmd_sequencer
  import alu_defs_pkg::*;
#(
  parameter int W     = 6,
  parameter int DEPTH = 4
`ifdef ALU_SEQ_STATS_EN
  ,
  parameter int CNT_W = 8
`endif
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_op,
  input  logic [W-1:0] cmd_a,
  input  logic [W-1:0] cmd_b,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic         alu_carry_in,
  output logic [3:0]   alu_op,
  input  logic [W-1:0] alu_result,
  input  logic         alu_carry_out,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_result,
  output logic         rsp_carry,
  output logic         rsp_zero,
  output logic         rsp_err
`ifdef ALU_SEQ_STATS_EN
  ,
  output logic [CNT_W-1:0] rsp_count
`endif
);

  localparam int FW = 2 * W + 3;

  state_t         r_state;
  state_t         w_next;
  logic           w_pop;
  logic           w_capture;
  logic           w_full;
  logic           w_empty;
  logic [FW-1:0]  w_head;
  logic [2:0]     w_head_op;
  logic [W-1:0]   w_head_a;
  logic [W-1:0]   w_head_b;
  dec_t           w_dec;

  logic [W-1:0]   r_alu_a;
  logic [W-1:0]   r_alu_b;
  logic           r_alu_ci;
  logic [3:0]     r_alu_op;
  logic           r_err;
  logic           r_arith;
  logic           r_rsp_valid;
  logic [W-1:0]   r_rsp_result;
  logic           r_rsp_carry;
  logic           r_rsp_zero;
  logic           r_rsp_err;

  assign cmd_ready = ~w_full;

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (cmd_valid & cmd_ready),
    .i_data  ({cmd_op, cmd_a, cmd_b}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign {w_head_op, w_head_a, w_head_b} = w_head;
  assign w_dec = decode_cmd(w_head_op);

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next state plus pop/capture strobes
  always_comb begin
    w_next    = r_state;
    w_pop     = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop  = 1'b1;
          w_next = EXEC;
        end
      end
      EXEC: begin
        w_capture = 1'b1;
        w_next    = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          w_pop  = ~w_empty;
          w_next = w_empty ? IDLE : EXEC;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // ALU drive registers: loaded on pop, held otherwise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_alu_a  <= '0;
      r_alu_b  <= '0;
      r_alu_ci <= 1'b0;
      r_alu_op <= ALUOP_AND;
      r_err    <= 1'b0;
      r_arith  <= 1'b0;
    end else if (w_pop) begin
      r_alu_a  <= w_dec.err ? '0 : w_head_a;
      r_alu_b  <= w_dec.err ? '0 : w_head_b;
      r_alu_ci <= w_dec.carry_in;
      r_alu_op <= w_dec.alu_op;
      r_err    <= w_dec.err;
      r_arith  <= w_dec.arith;
    end
  end

  // Response capture at the end of EXEC; valid drops on handshake
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_carry  <= 1'b0;
      r_rsp_zero   <= 1'b0;
      r_rsp_err    <= 1'b0;
    end else if (w_capture) begin
      r_rsp_valid  <= 1'b1;
      r_rsp_result <= r_err ? '0 : alu_result;
      r_rsp_carry  <= r_arith & ~r_err & alu_carry_out;
      r_rsp_zero   <= r_err | (alu_result == '0);
      r_rsp_err    <= r_err;
    end else if (r_rsp_valid && rsp_ready) begin
      r_rsp_valid  <= 1'b0;
    end
  end

  assign alu_a        = r_alu_a;
  assign alu_b        = r_alu_b;
  assign alu_carry_in = r_alu_ci;
  assign alu_op       = r_alu_op;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_result   = r_rsp_result;
  assign rsp_carry    = r_rsp_carry;
  assign rsp_zero     = r_rsp_zero;
  assign rsp_err      = r_rsp_err;

`ifdef ALU_SEQ_STATS_EN
  logic [CNT_W-1:0] r_rsp_count;

  // Completed-response counter, sticks at all-ones
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_rsp_count <= '0;
    else if (r_rsp_valid && rsp_ready && (r_rsp_count != '1))
      r_rsp_count <= r_rsp_count + CNT_W'(1);
  end

  assign rsp_count = r_rsp_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_cmd_sequencer
//  Description : Directed self-checking bench for alu_cmd_sequencer with a
//                behavioural 6-bit ALU closing the loop. Build with
//                ALU_SEQ_STATS_EN to exercise the response counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_cmd_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [5:0] cmd_a, cmd_b;
  logic [5:0] alu_a, alu_b;
  logic       alu_carry_in;
  logic [3:0] alu_op;
  logic [5:0] alu_result;
  logic       alu_carry_out;
  logic       rsp_valid, rsp_ready;
  logic [5:0] rsp_result;
  logic       rsp_carry, rsp_zero, rsp_err;
`ifdef ALU_SEQ_STATS_EN
  logic [1:0] rsp_count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

`ifdef ALU_SEQ_STATS_EN
  alu_cmd_sequencer #(.W(6), .DEPTH(4), .CNT_W(2)) dut (
`else
  alu_cmd_sequencer #(.W(6), .DEPTH(4)) dut (
`endif
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_carry_in(alu_carry_in), .alu_op(alu_op),
    .alu_result(alu_result), .alu_carry_out(alu_carry_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
`ifdef ALU_SEQ_STATS_EN
    , .rsp_count(rsp_count)
`endif
  );

  // Behavioural ALU: Ainvert/Bnegate, adder always computes CarryOut
  logic [5:0] w_aa, w_bb;
  logic [6:0] w_sum;
  always_comb begin
    w_aa  = alu_op[3] ? ~alu_a : alu_a;
    w_bb  = alu_op[2] ? ~alu_b : alu_b;
    w_sum = {1'b0, w_aa} + {1'b0, w_bb} + {6'b0, alu_carry_in};
    case (alu_op[1:0])
      2'b00:   alu_result = w_aa & w_bb;
      2'b01:   alu_result = w_aa | w_bb;
      2'b10:   alu_result = w_sum[5:0];
      default: alu_result = 6'h00;
    endcase
    alu_carry_out = w_sum[6];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present a command for one edge; caller is #1 after an edge
  task automatic drive_cmd(input logic [2:0] op, input logic [5:0] a, input logic [5:0] b);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic push_cmd(input logic [2:0] op, input logic [5:0] a, input logic [5:0] b);
    int k = 0;
    while (cmd_ready !== 1'b1 && k < 20) begin
      @(posedge clk); #1; k++;
    end
    if (cmd_ready !== 1'b1) check("push_ready_timeout", cmd_ready, 1);
    drive_cmd(op, a, b);
  endtask

  // Wait (bounded) for a response, check it, consume it with rsp_ready=1
  task automatic expect_rsp(input string tag, input logic [5:0] r, input logic c,
                            input logic z, input logic e);
    int k = 0;
    while (rsp_valid !== 1'b1 && k < 20) begin
      @(posedge clk); #1; k++;
    end
    check({tag, "_valid"}, rsp_valid, 1);
    check({tag, "_result"}, rsp_result, r);
    check({tag, "_carry"}, rsp_carry, c);
    check({tag, "_zero"}, rsp_zero, z);
    check({tag, "_err"}, rsp_err, e);
    @(posedge clk); #1;
  endtask

  // Observe rsp_valid for n cycles; returns 1 if it ever rose
  task automatic watch_quiet(input int n, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (rsp_valid === 1'b1) seen = 1'b1;
    end
  endtask

  logic seen;

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_alu_op", alu_op, 4'b0000);
    check("rst_alu_a", alu_a, 0);
    check("rst_rsp_result", rsp_result, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("rst_cmd_ready", cmd_ready, 1);

    // 1: ADD 3F+01 with 2-edge latency
    rsp_ready = 1'b1;
    drive_cmd(3'd2, 6'h3F, 6'h01);
    check("t1_e0_valid", rsp_valid, 0);
    @(posedge clk); #1;
    check("t1_e1_valid", rsp_valid, 0);
    check("t1_alu_op", alu_op, 4'b0010);
    check("t1_alu_ci", alu_carry_in, 0);
    check("t1_alu_a", alu_a, 6'h3F);
    @(posedge clk); #1;
    check("t1_e2_valid", rsp_valid, 1);
    check("t1_result", rsp_result, 6'h00);
    check("t1_carry", rsp_carry, 1);
    check("t1_zero", rsp_zero, 1);
    check("t1_err", rsp_err, 0);
    @(posedge clk); #1;
    check("t1_after_hs", rsp_valid, 0);

    // 2: SUB 5-7
    drive_cmd(3'd3, 6'd5, 6'd7);
    @(posedge clk); #1;
    check("t2_alu_op", alu_op, 4'b0110);
    check("t2_alu_ci", alu_carry_in, 1);
    expect_rsp("t2", 6'h3E, 1'b0, 1'b0, 1'b0);

    // 3: back-pressure fills FIFO plus one held in RESP
    rsp_ready = 1'b0;
    push_cmd(3'd0, 6'h3F, 6'h3F);
    push_cmd(3'd1, 6'h05, 6'h0A);
    push_cmd(3'd4, 6'h0F, 6'h30);
    push_cmd(3'd2, 6'h10, 6'h20);
    push_cmd(3'd3, 6'd9, 6'd9);
    check("t3_full_ready", cmd_ready, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("t3_hold_ready", cmd_ready, 0);
    check("t3_hold_valid", rsp_valid, 1);
    check("t3_and_result", rsp_result, 6'h3F);
    check("t3_and_carry", rsp_carry, 0);
    check("t3_and_zero", rsp_zero, 0);
    // pop while full: the offered command must not enter
    rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_op = 3'd2; cmd_a = 6'h01; cmd_b = 6'h01;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("t3_ready_after_pop", cmd_ready, 1);
    expect_rsp("t3_or", 6'h0F, 1'b0, 1'b0, 1'b0);
    expect_rsp("t3_nor", 6'h00, 1'b0, 1'b1, 1'b0);
    expect_rsp("t3_add", 6'h30, 1'b0, 1'b0, 1'b0);
    expect_rsp("t3_sub", 6'h00, 1'b1, 1'b1, 1'b0);
    watch_quiet(6, seen);
    check("t3_no_extra", seen, 0);

    // 4: illegal op, then normal ADD
    drive_cmd(3'd6, 6'h3F, 6'h3F);
    @(posedge clk); #1;
    check("t4_alu_op", alu_op, 4'b0000);
    check("t4_alu_a", alu_a, 0);
    check("t4_alu_b", alu_b, 0);
    expect_rsp("t4_ill", 6'h00, 1'b0, 1'b1, 1'b1);
    push_cmd(3'd2, 6'h01, 6'h02);
    expect_rsp("t4_add", 6'h03, 1'b0, 1'b0, 1'b0);

    // 5: reset in RESP with three entries queued
    rsp_ready = 1'b0;
    push_cmd(3'd2, 6'h01, 6'h01);
    push_cmd(3'd2, 6'h02, 6'h02);
    push_cmd(3'd2, 6'h03, 6'h03);
    push_cmd(3'd2, 6'h04, 6'h04);
    check("t5_in_resp", rsp_valid, 1);
    #2 reset = 1'b1;
    #1;
    check("t5_rst_valid", rsp_valid, 0);
    @(posedge clk);
    @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk); #1;
    check("t5_ready_after", cmd_ready, 1);
    rsp_ready = 1'b1;
    watch_quiet(8, seen);
    check("t5_no_stale", seen, 0);
    push_cmd(3'd2, 6'h07, 6'h09);
    expect_rsp("t5_add", 6'h10, 1'b0, 1'b0, 1'b0);
`ifdef ALU_SEQ_STATS_EN
    check("t6_count1", rsp_count, 2'd1);
`endif

    // 6: four more completions (counter saturation when enabled)
    push_cmd(3'd2, 6'h20, 6'h20);
    expect_rsp("t6_a", 6'h00, 1'b1, 1'b1, 1'b0);
    push_cmd(3'd1, 6'h21, 6'h12);
    expect_rsp("t6_b", 6'h33, 1'b0, 1'b0, 1'b0);
    push_cmd(3'd0, 6'h2A, 6'h15);
    expect_rsp("t6_c", 6'h00, 1'b0, 1'b1, 1'b0);
    push_cmd(3'd3, 6'h08, 6'h03);
    expect_rsp("t6_d", 6'h05, 1'b1, 1'b0, 1'b0);
`ifdef ALU_SEQ_STATS_EN
    check("t6_count_sat", rsp_count, 2'd3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
